// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like memory responder.
// Holds the size encodings, the response-queue entry and the LFSR constants.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Wide enough for LAT-1 plus up to 3 extra delay cycles for any sane LAT.
  localparam int CNT_W = 8;

  typedef struct packed {
    logic             is_write;
    logic [31:0]      rdata;
    logic [CNT_W-1:0] ready_cnt;
  } resp_entry_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Galois right-shift step; taps 16,14,13,11 give a maximal-length sequence.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// Bundle of the sram-like request/response signals between a CPU-side
// initiator (master) and the memory responder (slave).
interface sram_like_responder_if;
  import sram_like_pkg::*;

  logic        req;
  logic        wr;
  size_e       size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_responder_resp_queue.sv
// In-order response FIFO: each entry counts down to zero independently and
// the head is popped (one response) as soon as its count reaches zero.
module resp_queue
  import sram_like_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        push_i,
  input  resp_entry_t push_entry_i,
  output logic        full_o,
  output logic        resp_valid_o,
  output logic        resp_is_write_o,
  output logic [31:0] resp_rdata_o
);

  localparam int PTR_W = $clog2(QDEPTH);

  resp_entry_t      slots_q [QDEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  resp_entry_t      head_entry;
  logic             pop;

  assign head_entry = slots_q[head_q];
  assign pop        = (count_q != '0) && (head_entry.ready_cnt == '0);

  assign full_o          = (count_q == (PTR_W+1)'(QDEPTH));
  assign resp_valid_o    = pop;
  assign resp_is_write_o = head_entry.is_write;
  assign resp_rdata_o    = head_entry.rdata;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)    head_d = head_q + 1'b1;
    if (push_i) tail_d = tail_q + 1'b1;
    case ({push_i, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) slots_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < QDEPTH; i++) begin
        if (push_i && (tail_q == PTR_W'(i))) begin
          slots_q[i] <= push_entry_i;
        end else if (slots_q[i].ready_cnt != '0) begin
          slots_q[i].ready_cnt <= slots_q[i].ready_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// Word-addressed memory behind an sram-like bus with in-order, fixed-latency
// responses. Define RESP_RAND_DELAY_EN for LFSR-driven extra latency/stalls.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int LAT    = 2,
  parameter int QDEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  sram_like_responder_if.slave bus
);

  logic [31:0]       mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              full;
  logic              stall;
  logic [1:0]        extra;
  logic              resp_valid;
  logic              resp_is_write;
  logic [31:0]       resp_rdata;
  resp_entry_t       new_entry;
  logic              unused_bits;

  // Upper address bits are dropped, so the array aliases modulo its size.
  assign idx         = bus.addr[ADDR_W+1:2];
  assign bus.addr_ok = !full && !reset && !stall;
  assign accept      = bus.req && bus.addr_ok;

`ifdef RESP_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign extra       = lfsr_q[1:0];
  assign stall       = lfsr_q[4];
  assign unused_bits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0],
                         lfsr_q[15:5], lfsr_q[3:2]};
`else
  assign extra       = 2'b00;
  assign stall       = 1'b0;
  assign unused_bits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};
`endif

  // Reads capture the array at acceptance, so they see every earlier write.
  always_comb begin
    new_entry.is_write  = bus.wr;
    new_entry.rdata     = bus.wr ? 32'h0 : mem_q[idx];
    new_entry.ready_cnt = CNT_W'(LAT - 1) + CNT_W'(extra);
  end

  // NOTE: the memory array has no reset; contents survive a reset and only
  // the control state is cleared.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.wstrb[k]) mem_q[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
      end
    end
  end

  resp_queue #(
    .QDEPTH (QDEPTH)
  ) u_resp_queue (
    .clk_i           (clk),
    .reset_i         (reset),
    .push_i          (accept),
    .push_entry_i    (new_entry),
    .full_o          (full),
    .resp_valid_o    (resp_valid),
    .resp_is_write_o (resp_is_write),
    .resp_rdata_o    (resp_rdata)
  );

  assign bus.data_ok = resp_valid && !reset;
  assign bus.rdata   = (bus.data_ok && !resp_is_write) ? resp_rdata : 32'h0;

endmodule

// File: tb/tb_sram_like_responder.sv
// Scoreboard bench for sram_like_responder: a LAT=2 instance for data-path
// tests and a LAT=8 instance for queue-full and reset-mid-flight tests.
module tb_sram_like_responder;
  import sram_like_pkg::*;

  localparam int LAT2 = 2;
  localparam int LAT8 = 8;

  typedef struct {
    logic        is_write;
    logic [31:0] rdata;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst2;
  logic rst8;

  always #5 clk = ~clk;

  sram_like_responder_if bus2 ();
  sram_like_responder_if bus8 ();

  sram_like_responder #(.ADDR_W(14), .LAT(LAT2), .QDEPTH(4)) u_dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2)
  );

  sram_like_responder #(.ADDR_W(14), .LAT(LAT8), .QDEPTH(4)) u_dut8 (
    .clk   (clk),
    .reset (rst8),
    .bus   (bus8)
  );

  exp_t        sb2[$];
  exp_t        sb8[$];
  logic [31:0] model2 [int];
  logic [31:0] model8 [int];
  int          n_vec  = 0;
  int          n_err  = 0;
  int          cyc    = 0;
  int          n_dok8 = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat, input int l);
`ifdef RESP_RAND_DELAY_EN
    check(tag, 32'((lat >= l) && (lat <= l + 3)), 32'd1);
`else
    check(tag, 32'(lat), 32'(l));
`endif
  endtask

  // Response monitor: pops the scoreboard on every data_ok.
  exp_t m_e;
  always @(negedge clk) begin
    if (bus2.data_ok) begin
      if (sb2.size() == 0) check("dok2_unexpected", 32'd1, 32'd0);
      else begin
        m_e = sb2.pop_front();
        check("rdata2", bus2.rdata, m_e.rdata);
        check_lat("lat2", cyc - m_e.acc_cyc, LAT2);
      end
    end else begin
      check("rdata2_idle", bus2.rdata, 32'h0);
    end
    if (bus8.data_ok) begin
      n_dok8++;
      if (sb8.size() == 0) check("dok8_unexpected", 32'd1, 32'd0);
      else begin
        m_e = sb8.pop_front();
        check("rdata8", bus8.rdata, m_e.rdata);
        check_lat("lat8", cyc - m_e.acc_cyc, LAT8);
      end
    end
  end

  task automatic drive(input bit s8, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    size_e sz = size_e'($urandom_range(0, 2));
    if (s8) begin
      bus8.req = r; bus8.wr = w; bus8.addr = a; bus8.wdata = wd; bus8.wstrb = st; bus8.size = sz;
    end else begin
      bus2.req = r; bus2.wr = w; bus2.addr = a; bus2.wdata = wd; bus2.wstrb = st; bus2.size = sz;
    end
  endtask

  function automatic logic aok(input bit s8);
    return s8 ? bus8.addr_ok : bus2.addr_ok;
  endfunction

  // Reference memory update and expected response at the acceptance point.
  task automatic record(input bit s8, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st);
    int          idx = int'(a[15:2]);
    exp_t        e;
    logic [31:0] m;
    if (s8) m = model8.exists(idx) ? model8[idx] : 32'h0;
    else    m = model2.exists(idx) ? model2[idx] : 32'h0;
    e.acc_cyc  = cyc;
    e.is_write = w;
    if (w) begin
      for (int k = 0; k < 4; k++) if (st[k]) m[8*k +: 8] = wd[8*k +: 8];
      if (s8) model8[idx] = m; else model2[idx] = m;
      e.rdata = 32'h0;
    end else begin
      e.rdata = m;
    end
    if (s8) sb8.push_back(e); else sb2.push_back(e);
  endtask

  task automatic issue(input bit s8, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    int tries = 0;
    @(posedge clk); #1 drive(s8, 1'b1, w, a, wd, st);
    forever begin
      @(negedge clk);
      if (aok(s8)) begin
        record(s8, w, a, wd, st);
        break;
      end
      tries++;
      if (tries > 64) begin
        check("addr_ok_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus2.req = 1'b0;
      bus8.req = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    idle(1);
    while ((sb2.size() != 0 || sb8.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("drain", 32'(sb2.size() + sb8.size()), 32'd0);
  endtask

  initial begin
    int          acc0;
    int          nxt;
    int          dok_before;
    logic        w;
    logic [31:0] a;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst2 = 1'b1;
    rst8 = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_aok2", 32'(bus2.addr_ok), 32'd0);
    check("rst_aok8", 32'(bus8.addr_ok), 32'd0);
    check("rst_dok2", 32'(bus2.data_ok), 32'd0);
    check("rst_dok8", 32'(bus8.data_ok), 32'd0);
    check("rst_rdata8", bus8.rdata, 32'h0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    rst8 = 1'b0;
    @(negedge clk);
    check("post_rst_aok2", 32'(bus2.addr_ok), 32'd1);
    check("post_rst_aok8", 32'(bus8.addr_ok), 32'd1);

    // Write then next-cycle read.
    issue(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    drain();

    // Byte strobe, then a zero-strobe write that must not change memory.
    issue(1'b0, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF);
    issue(1'b0, 1'b1, 32'h0000_0040, 32'h0000_00AA, 4'b0001);
    issue(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    issue(1'b0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000);
    issue(1'b0, 1'b0, 32'h0000_0042, 32'h0, 4'h0);
    drain();

    // Address wrap modulo 2^ADDR_W words.
    issue(1'b0, 1'b1, 32'h0001_0000, 32'h5A5A_5A5A, 4'hF);
    issue(1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
    drain();

    // Queue full on the LAT=8 instance.
    for (int i = 0; i < 6; i++) issue(1'b1, 1'b1, 32'h200 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF);
    drain();
    acc0 = -1;
    nxt  = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1 drive(1'b1, 1'b1, 1'b0, 32'h200 + 32'(4*nxt), 32'h0, 4'h0);
      @(negedge clk);
`ifndef RESP_RAND_DELAY_EN
      check("full_aok", 32'(aok(1'b1)), 32'(k < 4));
`endif
      if (aok(1'b1)) begin
        if (acc0 < 0) acc0 = cyc;
        record(1'b1, 1'b0, 32'h200 + 32'(4*nxt), 32'h0, 4'h0);
        nxt++;
      end
    end
    @(posedge clk); #1 bus8.req = 1'b0;
`ifndef RESP_RAND_DELAY_EN
    forever begin
      @(negedge clk);
      check("full_reassert", 32'(aok(1'b1)), 32'(cyc >= acc0 + 9));
      if (cyc >= acc0 + 9) break;
    end
`endif
    drain();

    // Reset mid-flight: accepted reads are dropped without data_ok.
    for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 32'h200 + 32'(4*i), 32'h0, 4'h0);
    @(posedge clk); #1;
    rst8     = 1'b1;
    bus8.req = 1'b0;
    sb8.delete();
    dok_before = n_dok8;
    @(negedge clk);
    check("midrst_aok8", 32'(bus8.addr_ok), 32'd0);
    check("midrst_dok8", 32'(bus8.data_ok), 32'd0);
    @(posedge clk); #1 rst8 = 1'b0;
    @(negedge clk);
    check("midrst_after_aok8", 32'(bus8.addr_ok), 32'd1);
    idle(15);
    check("midrst_no_dok", 32'(n_dok8 - dok_before), 32'd0);

    // Random traffic against the reference model over 32 aliased words.
    for (int i = 0; i < 32; i++) issue(1'b0, 1'b1, 32'(4*i), $urandom, 4'hF);
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 31)) << 2) | ($urandom & 32'h3);
      issue(1'b0, w, a, $urandom, 4'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
